// File: rtl/div_pkg.sv
//==============================================================================
// Module      : div_pkg
// Description : Shared widths, state encoding and constants for the restoring
//               divider (restoring_div_u and div_step).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 6;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_W-1:0] DIV_ZERO_QUO = {DIV_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Two's-complement magnitude. The most negative value maps onto itself,
    // which read as unsigned is exactly its magnitude.
    function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? (~v + DIV_W'(1)) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
//==============================================================================
// Module      : div_step
// Description : One combinational restoring-division step over the {rem,quo}
//               pair: shift left by one, trial-subtract the divisor from the
//               upper half, keep the difference (quo LSB=1) or restore
//               (quo LSB=0).
// Ports       : i_rem, i_quo - current partial remainder / quotient
//               i_dvs        - divisor magnitude
//               o_rem, o_quo - values after this step
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] i_rem,
    input  logic [DIV_W-1:0] i_quo,
    input  logic [DIV_W-1:0] i_dvs,
    output logic [DIV_W-1:0] o_rem,
    output logic [DIV_W-1:0] o_quo
);

    // The shifted remainder needs one extra bit: it can reach 2*dvs-1, and
    // the divisor magnitude may use all DIV_W bits.
    logic [DIV_W:0] w_part;
    logic [DIV_W:0] w_diff;

    assign w_part = {i_rem, i_quo[DIV_W-1]};
    assign w_diff = w_part - {1'b0, i_dvs};

    // w_part < 2*dvs, so the MSB of the difference is a clean borrow flag.
    always_comb begin
        o_rem = w_part[DIV_W-1:0];
        o_quo = {i_quo[DIV_W-2:0], 1'b0};
        if (!w_diff[DIV_W]) begin
            o_rem = w_diff[DIV_W-1:0];
            o_quo = {i_quo[DIV_W-2:0], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/restoring_div_u.sv
//==============================================================================
// Module      : restoring_div_u
// Description : Sequential 32-bit restoring divider. One quotient bit per
//               clock in CALC (32 cycles), sign fix-up in FIX, one-cycle done
//               pulse in DONE. Start-to-done latency is 33 edges; a zero
//               divisor goes straight to DONE.
// Config      : define DIV_SIGNED_EN for two's-complement operands (truncating
//               division, remainder takes the dividend's sign). Undefined:
//               unsigned operands, identical latency.
// Ports       : clk         - clock, rising edge
//               n_rst       - asynchronous active-low reset
//               start       - request, sampled only in IDLE
//               dividend    - numerator
//               divisor     - denominator
//               quotient    - registered quotient
//               remainder   - registered remainder
//               busy        - high in every state except IDLE
//               done        - one-cycle result-valid pulse
//               div_by_zero - registered divide-by-zero flag
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module restoring_div_u
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [DIV_W-1:0] r_dvs;
    logic [DIV_W-1:0] r_quotient;
    logic [DIV_W-1:0] r_remainder;
    logic             r_dbz;

    logic [DIV_W-1:0] w_a_mag;
    logic [DIV_W-1:0] w_b_mag;
    logic [DIV_W-1:0] w_step_rem;
    logic [DIV_W-1:0] w_step_quo;
    logic [DIV_W-1:0] w_fix_quo;
    logic [DIV_W-1:0] w_fix_rem;
    logic             w_accept;
    logic             w_zero;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && start;
    assign w_zero   = (divisor == '0);
    assign w_last   = (r_cnt == CNT_W'(DIV_W - 1));

`ifdef DIV_SIGNED_EN
    // Signs are captured with the operands; the core only sees magnitudes.
    logic r_q_neg;
    logic r_r_neg;

    assign w_a_mag   = div_mag(dividend);
    assign w_b_mag   = div_mag(divisor);
    assign w_fix_quo = r_q_neg ? (~r_quo + DIV_W'(1)) : r_quo;
    assign w_fix_rem = r_r_neg ? (~r_rem + DIV_W'(1)) : r_rem;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (w_accept) begin
            r_q_neg <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
            r_r_neg <= dividend[DIV_W-1];
        end
    end
`else
    assign w_a_mag   = dividend;
    assign w_b_mag   = divisor;
    assign w_fix_quo = r_quo;
    assign w_fix_rem = r_rem;
`endif

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = w_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
                r_rem <= '0;
                r_quo <= w_a_mag;
                r_dvs <= w_b_mag;
                // Divide-by-zero results are final at the start edge.
                if (w_zero) begin
                    r_quotient  <= DIV_ZERO_QUO;
                    r_remainder <= dividend;
                    r_dbz       <= 1'b1;
                end
            end
            if (r_state == CALC) begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == FIX) begin
                r_quotient  <= w_fix_quo;
                r_remainder <= w_fix_rem;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_restoring_div_u.sv
//==============================================================================
// Module      : tb_restoring_div_u
// Description : Self-checking bench for restoring_div_u. Directed cases plus
//               random operands against an arithmetic reference model.
//               Follows DIV_SIGNED_EN the same way as the design.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_restoring_div_u;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    restoring_div_u dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit integers.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
`else
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
`endif
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endtask

    // Present operands at a falling edge, hold start over one rising edge,
    // then scramble the operand inputs.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Called #1 after the start edge. inj>0 pulses a second start that many
    // edges into the operation.
    task automatic collect(input string tag, input logic [31:0] a, input logic [31:0] b, input int inj);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          n;
        int          lat;
        ref_div(a, b, eq, er, ez);
        lat = (b == 32'd0) ? 0 : 33;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == inj) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom | 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_quo"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        @(posedge clk);
        #1;
        chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_quo_hold"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          cnt;

        n_rst    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        #13;
        n_rst = 1'b1;
        #1;
        chk("rst_quo", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        // 20 / 8 with start raised at t=21
        #7;
        dividend = 32'd20;
        divisor  = 32'd8;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        collect("d20_8", 32'd20, 32'd8, 0);
`ifndef DIV_SIGNED_EN
        chk("d20_8_const_q", quotient, 32'd2);
`endif

        // -43 / 3 (unsigned: 0xFFFFFFD5 / 3)
        issue(32'hFFFF_FFD5, 32'd3);
        collect("neg43_3", 32'hFFFF_FFD5, 32'd3, 0);
`ifdef DIV_SIGNED_EN
        chk("neg43_3_const_q", quotient, 32'hFFFF_FFF2);
        chk("neg43_3_const_r", remainder, 32'hFFFF_FFFF);
`else
        chk("neg43_3_const_q", quotient, 32'h5555_5547);
        chk("neg43_3_const_r", remainder, 32'd0);
`endif

        // Divide by zero
        issue(32'h1234_5678, 32'd0);
        collect("dbz", 32'h1234_5678, 32'd0, 0);

        // Most negative / -1
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        collect("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Start pulse while busy is ignored
        issue(32'd1000, 32'd7);
        collect("busy_start", 32'd1000, 32'd7, 10);

        // Reset mid-CALC
        issue(32'hDEAD_BEEF, 32'd13);
        repeat (15) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("abort_quo", quotient, 32'd0);
        chk("abort_rem", remainder, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
        issue(32'd100, 32'd7);
        collect("after_abort", 32'd100, 32'd7, 0);
        chk("after_abort_q", quotient, 32'd14);
        chk("after_abort_r", remainder, 32'd2);

        // Random operands
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = (i % 8 == 0) ? 32'd0 : ($urandom | 32'h8000_0000);
            endcase
            issue(a, b);
            collect("rand", a, b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/restoring_div_u.md
RESTORING_DIV_U -- requirements
Module: restoring_div_u

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and n_rst.
REQ-002 clk  input  1  system clock.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  32  numerator, two's complement when DIV_SIGNED_EN is defined.
REQ-006 divisor  input  32  denominator, same encoding as dividend.
REQ-007 quotient  output  32  registered result.
REQ-008 remainder  output  32  registered result.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  high for exactly one cycle when results become valid.
REQ-011 div_by_zero  output  1  registered flag, valid together with done.

Function
REQ-012 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-013 In IDLE, start=1 at edge k SHALL latch dividend and divisor, clear the step counter, and enter CALC; start=1 with divisor=0 SHALL enter DONE instead.
REQ-014 CALC SHALL perform one restoring step per edge over a 64-bit {rem,quo} register:
- shift left by 1;
- trial-subtract |divisor| from the upper 32 bits;
- keep the difference and set quo LSB=1 if it is non-negative, else restore and set LSB=0.
REQ-015 CALC SHALL run exactly 32 edges (k+1..k+32), then go to FIX.
REQ-016 FIX SHALL apply sign correction and load quotient/remainder at edge k+33; state then goes to DONE.
REQ-017 DONE SHALL hold done=1 for one cycle and then return to IDLE; total latency is start edge to done high = 33 edges, i.e. done is high in the cycle after edge k+33.
REQ-018 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start completes.
REQ-019 start asserted while busy=1 SHALL be ignored; start held high SHALL begin a new operation only from IDLE.
REQ-020 On divide-by-zero, the block SHALL output quotient=32'hFFFF_FFFF, remainder=dividend, div_by_zero=1; done SHALL follow the start edge by one cycle.
REQ-021 Signed division SHALL truncate toward zero; the remainder SHALL take the dividend's sign; dividend = quotient*divisor + remainder SHALL hold.
REQ-022 Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield quotient=32'h8000_0000, remainder=0, div_by_zero=0 (wrap, no flag).
REQ-023 dividend and divisor changes after the start edge SHALL NOT affect the result.

Reset
REQ-024 n_rst=0 SHALL immediately force IDLE and clear quotient, remainder, the internal registers and the counter; done=0, busy=0, div_by_zero=0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL occur after release until a new start.

Configuration
REQ-026 With DIV_SIGNED_EN defined, operands SHALL be treated as two's complement: magnitudes are taken at the start edge and the signs are applied in FIX.
REQ-027 Without DIV_SIGNED_EN, operands SHALL be unsigned, FIX SHALL pass results through unchanged, and latency SHALL be identical.

Structure
REQ-028 Package div_pkg SHALL hold DIV_W=32, CNT_W=6, the state enum type, and the divide-by-zero quotient constant.
REQ-029 One combinational sub-module, div_step, SHALL implement a single shift/trial-subtract/restore step; restoring_div_u SHALL instantiate it once.

Verification
REQ-030 dividend=20, divisor=8, start pulse at 21 ps -> after 33 edges: quotient=2, remainder=4, done single pulse.
REQ-031 (signed) dividend=32'hFFFF_FFD5 (-43), divisor=3 -> quotient=32'hFFFF_FFF2 (-14), remainder=32'hFFFF_FFFF (-1); unsigned build -> quotient=32'h5555_5547, remainder=0.
REQ-032 dividend=32'h1234_5678, divisor=0 -> done one cycle after start; quotient=32'hFFFF_FFFF, remainder=32'h1234_5678, div_by_zero=1.
REQ-033 (signed) 32'h8000_0000 / 32'hFFFF_FFFF -> quotient=32'h8000_0000, remainder=0, div_by_zero=0.
REQ-034 A second start pulse 10 cycles into CALC with different operands -> ignored; the first result is unchanged and only one done pulse occurs.
REQ-035 n_rst low for one cycle at step 15 -> outputs=0 at once, no done; a fresh start 100/7 -> quotient=14, remainder=2.
